// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and func3 constants, LSU state encoding and
// the request record captured by the load/store unit.
package cpu_pkg;

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_t;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } lsu_size_t;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Unlisted func3 encodings fall back to a full-word access.
  function automatic lsu_size_t f3_size(logic [2:0] f3);
    lsu_size_t sz;
    unique case (f3)
      F3Byte, F3ByteU: sz = SzByte;
      F3Half, F3HalfU: sz = SzHalf;
      F3Word:          sz = SzWord;
      default:         sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] addr_lo);
    logic mis;
    unique case (f3_size(f3))
      SzHalf:  mis = addr_lo[0];
      SzWord:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface mem_lsu_if;

  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_gnt,
    input  dm_rvalid,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_gnt,
    output dm_rvalid,
    output dm_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and lane-replicated write data, load lane
// extraction with sign/zero extension. Misaligned low address bits are ignored.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  lsu_size_t   size;
  logic        zext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size     = f3_size(func3);
  assign zext     = func3[2];
  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be      = 4'b0000;
    wdata   = '0;
    ld_data = '0;
    unique case (size)
      SzByte: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SzHalf: begin
        be      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata   = {2{st_data[15:0]}};
        ld_data = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// M-stage load/store unit: IDLE/REQ/WAIT/DONE handshake with data memory.
// Optional MISALIGN_CHECK_EN adds MEM_misalign and suppresses misaligned accesses.
module mem_lsu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_DONE,
  input  logic [4:0]  MEM_op,
  input  logic [2:0]  MEM_func3,
  input  logic [31:0] MEM_aluOut,
  input  logic [31:0] MEM_rs2_data,
  output logic        MEM_DONE,
  output logic [31:0] MEM_ld_data,
`ifdef MISALIGN_CHECK_EN
  output logic        MEM_misalign,
`endif
  mem_lsu_if.master   dm
);

  lsu_state_t  state_q, state_d;
  lsu_req_t    live_req, req_q, cur_req;
  logic        mem_op;
  logic        live_misalign;
  logic        req_c;
  logic [31:0] ld_q, ld_d;
  logic [31:0] ld_ext;
  logic [3:0]  be;
  logic [31:0] wdata_lane;

  assign mem_op = (MEM_op == OpLoad) || (MEM_op == OpStore);

  always_comb begin
    live_req.is_load = (MEM_op == OpLoad);
    live_req.func3   = MEM_func3;
    live_req.addr    = MEM_aluOut;
    live_req.wdata   = MEM_rs2_data;
  end

  // Once issued, the request is replayed from req_q so dm_* cannot drift in REQ/WAIT.
  assign cur_req = (state_q == StIdle) ? live_req : req_q;

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;

  assign live_misalign = mem_op && is_misaligned(MEM_func3, MEM_aluOut[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (state_q == StIdle) begin
      misalign_q <= live_misalign;
    end
  end

  assign MEM_misalign = misalign_q && (state_q == StDone);
`else
  assign live_misalign = 1'b0;
`endif

  lsu_align u_align (
    .func3   (cur_req.func3),
    .addr_lo (cur_req.addr[1:0]),
    .st_data (cur_req.wdata),
    .rdata   (dm.dm_rdata),
    .be      (be),
    .wdata   (wdata_lane),
    .ld_data (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ld_q    <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      if (state_q == StIdle) begin
        req_q <= live_req;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    req_c    = 1'b0;
    MEM_DONE = 1'b0;
    unique case (state_q)
      StIdle, StReq: begin
        if ((state_q == StIdle) && !mem_op) begin
          MEM_DONE = 1'b1;
        end else if ((state_q == StIdle) && live_misalign) begin
          state_d = StDone;
          ld_d    = '0;
        end else begin
          req_c = 1'b1;
          if (!dm.dm_gnt) begin
            state_d = StReq;
          end else if (!cur_req.is_load) begin
            state_d = StDone;
          end else if (dm.dm_rvalid) begin
            state_d = StDone;
            ld_d    = ld_ext;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dm.dm_rvalid) begin
          state_d = StDone;
          ld_d    = ld_ext;
        end
      end
      StDone: begin
        MEM_DONE = 1'b1;
        if (IF_DONE) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The IDLE request is combinational on the op, so reset must mask it directly.
  assign dm.dm_req     = req_c & rst_n;
  assign dm.dm_we      = (req_c && !cur_req.is_load) ? be : 4'b0000;
  assign dm.dm_addr    = {cur_req.addr[31:2], 2'b00};
  assign dm.dm_wdata   = wdata_lane;
  assign MEM_ld_data   = ld_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: table of single accesses with a load-result
// scoreboard, plus hand sequences for DONE hold, reset abort and misalignment.
module tb_mem_lsu;
  import cpu_pkg::*;

  localparam logic [4:0] OpNop = 5'b01100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IF_DONE;
  logic [4:0]  MEM_op;
  logic [2:0]  MEM_func3;
  logic [31:0] MEM_aluOut;
  logic [31:0] MEM_rs2_data;
  logic        MEM_DONE;
  logic [31:0] MEM_ld_data;
`ifdef MISALIGN_CHECK_EN
  logic        MEM_misalign;
`endif

  mem_lsu_if dm_bus ();

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IF_DONE      (IF_DONE),
    .MEM_op       (MEM_op),
    .MEM_func3    (MEM_func3),
    .MEM_aluOut   (MEM_aluOut),
    .MEM_rs2_data (MEM_rs2_data),
    .MEM_DONE     (MEM_DONE),
    .MEM_ld_data  (MEM_ld_data),
`ifdef MISALIGN_CHECK_EN
    .MEM_misalign (MEM_misalign),
`endif
    .dm           (dm_bus)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    logic [3:0]  we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  logic [31:0] last_ld;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  function automatic void add(input logic [4:0] op, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int g, input int r,
                              input logic [3:0] we, input logic [31:0] daddr,
                              input logic [31:0] wdata, input logic [31:0] ld);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.gdly = g; v.rdly = r; v.we = we; v.daddr = daddr; v.wdata = wdata; v.ld = ld;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic        is_ld;
    int          last;
    logic [31:0] exp_ld;
    is_ld = (v.op == OpLoad);
    last  = is_ld ? v.gdly + v.rdly : v.gdly;
    sb_q.push_back(is_ld ? v.ld : last_ld);
    if (is_ld) last_ld = v.ld;
    @(negedge clk);
    MEM_op       = v.op;
    MEM_func3    = v.f3;
    MEM_aluOut   = v.addr;
    MEM_rs2_data = v.rs2;
    dm_bus.dm_rdata = v.rdata;
    for (int k = 0; k <= last; k++) begin
      dm_bus.dm_gnt    = (k == v.gdly);
      dm_bus.dm_rvalid = is_ld && (k == last);
      #1;
      chk1($sformatf("v%0d_busy_k%0d", idx, k), MEM_DONE, 1'b0);
      if (k <= v.gdly) begin
        chk1($sformatf("v%0d_req_k%0d", idx, k), dm_bus.dm_req, 1'b1);
        chk($sformatf("v%0d_we_k%0d", idx, k), 32'(dm_bus.dm_we), 32'(v.we));
        chk($sformatf("v%0d_addr_k%0d", idx, k), dm_bus.dm_addr, v.daddr);
        if (!is_ld) chk($sformatf("v%0d_wdata_k%0d", idx, k), dm_bus.dm_wdata, v.wdata);
      end else begin
        chk1($sformatf("v%0d_noreq_k%0d", idx, k), dm_bus.dm_req, 1'b0);
      end
      @(negedge clk);
    end
    dm_bus.dm_gnt    = 1'b0;
    dm_bus.dm_rvalid = 1'b0;
    #1;
    chk1($sformatf("v%0d_done", idx), MEM_DONE, 1'b1);
    chk1($sformatf("v%0d_done_noreq", idx), dm_bus.dm_req, 1'b0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d_sb: scoreboard empty", idx);
    end else begin
      exp_ld = sb_q.pop_front();
      chk($sformatf("v%0d_ld", idx), MEM_ld_data, exp_ld);
    end
    MEM_op = OpNop;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //   op       f3       addr          rs2           rdata         g  r  we       daddr         wdata         ld
    add(OpStore, F3Word,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 0, 4'b1111, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0);
    add(OpLoad,  F3Byte,  32'h0000_0103, 32'h0,         32'h80FF_1234, 2, 3, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80);
    add(OpLoad,  F3HalfU, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 0, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_BEEF);
    add(OpStore, F3Byte,  32'h0000_0201, 32'h0000_00A5, 32'h0,        1, 0, 4'b0010, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0);
    add(OpStore, F3Half,  32'h0000_0206, 32'h1234_CAFE, 32'h0,        0, 0, 4'b1100, 32'h0000_0204, 32'hCAFE_CAFE, 32'h0);
    add(OpLoad,  F3Half,  32'h0000_0300, 32'h0,         32'h0000_8001, 1, 1, 4'b0000, 32'h0000_0300, 32'h0,        32'hFFFF_8001);
    add(OpLoad,  F3ByteU, 32'h0000_0301, 32'h0,         32'h0000_F000, 0, 2, 4'b0000, 32'h0000_0300, 32'h0,        32'h0000_00F0);
    add(OpLoad,  F3Word,  32'h0000_0400, 32'h0,         32'h1357_9BDF, 1, 0, 4'b0000, 32'h0000_0400, 32'h0,        32'h1357_9BDF);
    add(OpLoad,  3'b111,  32'h0000_0500, 32'h0,         32'hCAFE_F00D, 0, 1, 4'b0000, 32'h0000_0500, 32'h0,        32'hCAFE_F00D);
    add(OpStore, 3'b011,  32'h0000_0600, 32'h0102_0304, 32'h0,        2, 0, 4'b1111, 32'h0000_0600, 32'h0102_0304, 32'h0);
    add(OpLoad,  F3Byte,  32'h0000_0102, 32'h0,         32'h007F_0000, 0, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_007F);
    add(OpLoad,  F3HalfU, 32'h0000_0100, 32'h0,         32'h1234_ABCD, 3, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_ABCD);
`ifndef MISALIGN_CHECK_EN
    add(OpLoad,  F3Half,  32'h0000_0303, 32'h0,         32'hA5A5_7FFF, 0, 1, 4'b0000, 32'h0000_0300, 32'h0,        32'hFFFF_A5A5);
    add(OpStore, F3Half,  32'h0000_0203, 32'h0000_1111, 32'h0,        0, 0, 4'b1100, 32'h0000_0200, 32'h1111_1111, 32'h0);
    add(OpLoad,  F3Word,  32'h0000_0107, 32'h0,         32'h89AB_CDEF, 1, 1, 4'b0000, 32'h0000_0104, 32'h0,        32'h89AB_CDEF);
`endif

    // Reset with a load pending: no request, cleared result.
    rst_n = 1'b0;
    IF_DONE = 1'b1;
    MEM_op = OpLoad;
    MEM_func3 = F3Word;
    MEM_aluOut = 32'h0000_0100;
    MEM_rs2_data = 32'h0;
    dm_bus.dm_gnt = 1'b0;
    dm_bus.dm_rvalid = 1'b0;
    dm_bus.dm_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req", dm_bus.dm_req, 1'b0);
    chk("rst_ld", MEM_ld_data, 32'h0);
    rst_n = 1'b1;
    MEM_op = OpNop;
    #1;
    chk1("idle_nop_done", MEM_DONE, 1'b1);
    chk1("idle_nop_req", dm_bus.dm_req, 1'b0);
    last_ld = 32'h0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Completed load held in DONE while IF_DONE is low; responses ignored there.
    @(negedge clk);
    IF_DONE = 1'b0;
    MEM_op = OpLoad;
    MEM_func3 = F3Word;
    MEM_aluOut = 32'h0000_0700;
    dm_bus.dm_rdata = 32'h0BAD_F00D;
    dm_bus.dm_gnt = 1'b1;
    dm_bus.dm_rvalid = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      dm_bus.dm_gnt = (j == 1);
      dm_bus.dm_rvalid = (j == 1);
      dm_bus.dm_rdata = (j == 1) ? 32'hFFFF_FFFF : 32'h0BAD_F00D;
      #1;
      chk1($sformatf("hold%0d_done", j), MEM_DONE, 1'b1);
      chk1($sformatf("hold%0d_req", j), dm_bus.dm_req, 1'b0);
      chk($sformatf("hold%0d_ld", j), MEM_ld_data, 32'h0BAD_F00D);
      @(negedge clk);
    end
    dm_bus.dm_gnt = 1'b0;
    dm_bus.dm_rvalid = 1'b0;
    IF_DONE = 1'b1;
    #1;
    chk1("hold_release_done", MEM_DONE, 1'b1);
    @(negedge clk);
    #1;
    chk1("hold_idle_req", dm_bus.dm_req, 1'b1);
    chk1("hold_idle_busy", MEM_DONE, 1'b0);
    MEM_op = OpNop;

    // Reset in WAIT aborts the access; a late response must not land.
    @(negedge clk);
    MEM_op = OpLoad;
    MEM_func3 = F3Word;
    MEM_aluOut = 32'h0000_0800;
    dm_bus.dm_gnt = 1'b1;
    @(negedge clk);
    dm_bus.dm_gnt = 1'b0;
    #1;
    chk1("wait_noreq", dm_bus.dm_req, 1'b0);
    chk1("wait_busy", MEM_DONE, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("wait_rst_req", dm_bus.dm_req, 1'b0);
    chk("wait_rst_ld", MEM_ld_data, 32'h0);
    @(negedge clk);
    MEM_op = OpNop;
    rst_n = 1'b1;
    dm_bus.dm_rvalid = 1'b1;
    dm_bus.dm_rdata = 32'h1234_5678;
    #1;
    chk1("late_done", MEM_DONE, 1'b1);
    @(negedge clk);
    dm_bus.dm_rvalid = 1'b0;
    #1;
    chk("late_ld", MEM_ld_data, 32'h0);
    MEM_op = OpLoad;
    #1;
    chk1("late_idle_req", dm_bus.dm_req, 1'b1);
    MEM_op = OpNop;

`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    MEM_op = OpLoad;
    MEM_func3 = F3Word;
    MEM_aluOut = 32'h0000_0101;
    #1;
    chk1("mis_req0", dm_bus.dm_req, 1'b0);
    chk1("mis_busy", MEM_DONE, 1'b0);
    chk1("mis_flag0", MEM_misalign, 1'b0);
    @(negedge clk);
    #1;
    chk1("mis_req1", dm_bus.dm_req, 1'b0);
    chk1("mis_done", MEM_DONE, 1'b1);
    chk1("mis_flag1", MEM_misalign, 1'b1);
    chk("mis_ld", MEM_ld_data, 32'h0);
    MEM_op = OpNop;
    @(negedge clk);
    #1;
    chk1("mis_flag_clr", MEM_misalign, 1'b0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: IF_DONE  in  1  fetch side ready; the pipeline advances when IF_DONE && MEM_DONE.
REQ-004 SHALL have: MEM_op  in  5  opcode[6:2] of the M-stage instruction (LOAD=5'b00000, STORE=5'b01000).
REQ-005 SHALL have: MEM_func3  in  3  width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have: MEM_aluOut  in  32  effective byte address.
REQ-007 SHALL have: MEM_rs2_data  in  32  store source data.
REQ-008 SHALL have: MEM_DONE  out  1  M-stage complete; it is the stall input of the EX/MEM and upstream pipeline registers.
REQ-009 SHALL have: MEM_ld_data  out  32  extended load result.
REQ-010 SHALL have: dm_req  out  1, dm_we  out  4 (byte strobes, 0 = read), dm_addr  out  32 (word aligned, [1:0]=0), dm_wdata  out  32  data-memory request.
REQ-011 SHALL have: dm_gnt  in  1  request accepted; dm_rvalid  in  1, dm_rdata  in  32  read response.

Function
REQ-012 SHALL implement the FSM IDLE, REQ, WAIT, DONE.
REQ-013 IDLE with a non-memory op: MEM_DONE=1 combinationally, dm_req=0, state held.
REQ-014 IDLE with LOAD/STORE: dm_req=1 in the same cycle. On dm_gnt, go to WAIT (load) or DONE (store). Without dm_gnt, go to REQ.
REQ-015 REQ: hold dm_req and all dm_* outputs stable until dm_gnt, then take the REQ-014 transitions.
REQ-016 Load: dm_gnt && dm_rvalid in the same cycle (IDLE or REQ) goes directly to DONE and captures data.
REQ-017 WAIT: dm_req=0. On dm_rvalid, register the extended data into MEM_ld_data and go to DONE.
REQ-018 DONE: MEM_ld_data held, MEM_DONE=1. On IF_DONE=1, go to IDLE; otherwise stay in DONE, so the request is never reissued.
REQ-019 MEM_DONE SHALL be 0 in REQ, in WAIT, and in IDLE while a memory op is pending.
REQ-020 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-021 Store data: dm_wdata = rs2 byte/half replicated across all lanes.
REQ-022 Load extract: select lane by addr[1:0]. func3[2]=0 sign-extends, func3[2]=1 zero-extends.
REQ-023 dm_rvalid or dm_gnt while in IDLE (no op) or DONE SHALL be ignored.
REQ-024 Undefined func3 values SHALL be treated as W.

Reset
REQ-025 rst_n=0 SHALL force, at any time: state=IDLE, MEM_ld_data=0, dm_req=0.
REQ-026 Reset asserted in REQ or WAIT SHALL abort the access. A late dm_rvalid after reset SHALL NOT alter MEM_ld_data.

Configuration
REQ-027 With MISALIGN_CHECK_EN defined, output MEM_misalign (1 bit) SHALL exist.
REQ-028 Under MISALIGN_CHECK_EN, an H access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL:
  - issue no request;
  - go IDLE->DONE next cycle;
  - give MEM_ld_data=0 and MEM_misalign=1 while in DONE.
REQ-029 Without MISALIGN_CHECK_EN, the port SHALL be absent and the offending low address bits SHALL be ignored (access forced aligned).

Structure
REQ-030 Shared package cpu_pkg SHALL hold the opcode constants (LOAD, STORE), the func3 constants and the lsu_state_t enum.
REQ-031 Lane logic SHALL live in the combinational sub-module lsu_align: strobe and wdata generation, rdata extract and extend.

Verification
REQ-032 SW addr 0x104, rs2 0xDEADBEEF, dm_gnt high immediately -> dm_we=4'b1111, dm_addr=0x104; MEM_DONE=1 the next cycle.
REQ-033 LB addr 0x103, dm_gnt after 2 cycles, dm_rvalid 3 cycles later, rdata 0x80FF1234 -> MEM_ld_data=0xFFFFFF80; MEM_DONE low throughout the wait.
REQ-034 LHU addr 0x102, same-cycle dm_gnt+dm_rvalid, rdata 0xBEEF0000 -> DONE next cycle, MEM_ld_data=0x0000BEEF.
REQ-035 Load completes with IF_DONE=0 for 4 cycles -> stays in DONE, dm_req=0, MEM_ld_data stable; IDLE one cycle after IF_DONE=1.
REQ-036 rst_n pulsed low in WAIT, then dm_rvalid rdata 0x12345678 -> MEM_ld_data remains 0, state IDLE.
REQ-037 MISALIGN_CHECK_EN, LW addr 0x101 -> dm_req never 1, MEM_misalign=1, MEM_ld_data=0.
